// File: rtl/cam_sched_pkg.sv
// Shared types and constants for the camera frame scheduler.
// Optional build macro used by the top: CAMERA_SCHED_STATS_EN (drop counter).
package cam_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CFG,
    SKIP,
    ARMED,
    CAPTURE,
    STOPPING
  } state_t;

  typedef logic bank_t;

  localparam bank_t WR_BANK_RST = 1'b0;
  localparam bank_t RD_BANK_RST = 1'b1;

  // States in which iStop returns straight to IDLE (no frame in flight)
  function automatic logic is_pre_capture(state_t s);
    return (s == WAIT_CFG) || (s == SKIP) || (s == ARMED);
  endfunction

endpackage

// File: rtl/cam_vsync_edge.sv
// Resynchronises raw VSYNC and emits one-cycle rise (frame end) and
// fall (frame start) pulses, three clocks after the input edge.
module cam_vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_async,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic sync2_d;

  // Two-flop synchroniser followed by a registered edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      sync1   <= vsync_async;
      sync2   <= sync1;
      sync2_d <= sync2;
      rise    <= sync2 & ~sync2_d;
      fall    <= ~sync2 & sync2_d;
    end
  end

endmodule

// File: rtl/camera_frame_scheduler.sv
// Frame capture sequencer with a ping-pong two-bank frame store.
// Define CAMERA_SCHED_STATS_EN to build the saturating drop counter;
// otherwise oDropCnt reads as zero.
module camera_frame_scheduler
  import cam_sched_pkg::*;
#(
  parameter int unsigned SKIP_FRAMES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             iStart,
  input  logic             iStop,
  input  logic             iCfgDone,
  input  logic             iVsync,
  input  logic             iRdBusy,
  output logic             oCapEn,
  output logic             oWrBank,
  output logic             oRdBank,
  output logic             oRdValid,
  output logic             oSwap,
  output logic             oDrop,
  output logic [CNT_W-1:0] oFrameCnt,
  output logic [CNT_W-1:0] oDropCnt
);

  localparam int unsigned SKIP_W = (SKIP_FRAMES < 2) ? 1 : $clog2(SKIP_FRAMES + 1);
  localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(SKIP_FRAMES);

  state_t            state;
  logic [SKIP_W-1:0] skip_cnt;
  logic              fe;
  logic              fs;
  logic              complete_c;

  cam_vsync_edge u_vsync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync_async(iVsync),
    .rise       (fe),
    .fall       (fs)
  );

  // A frame is complete only if capture was open since its FS and config held
  assign complete_c = fe && oCapEn && iCfgDone &&
                      ((state == CAPTURE) || (state == STOPPING));

  // Sequencer, capture enable and bank ping-pong
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      skip_cnt  <= '0;
      oCapEn    <= 1'b0;
      oWrBank   <= WR_BANK_RST;
      oRdBank   <= RD_BANK_RST;
      oRdValid  <= 1'b0;
      oSwap     <= 1'b0;
      oDrop     <= 1'b0;
      oFrameCnt <= '0;
    end else begin
      oSwap <= 1'b0;
      oDrop <= 1'b0;

      if (is_pre_capture(state) && iStop) begin
        state  <= IDLE;
        oCapEn <= 1'b0;
      end else if ((state != IDLE) && !iCfgDone) begin
        state  <= WAIT_CFG;
        oCapEn <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (iStart && !iStop) state <= WAIT_CFG;
          end
          WAIT_CFG: begin
            if (SKIP_FRAMES == 0) begin
              state <= ARMED;
            end else begin
              state    <= SKIP;
              skip_cnt <= SKIP_LOAD;
            end
          end
          SKIP: begin
            if (fe) begin
              if (skip_cnt <= SKIP_W'(1)) state <= ARMED;
              else skip_cnt <= skip_cnt - SKIP_W'(1);
            end
          end
          ARMED: begin
            if (fs) begin
              state  <= CAPTURE;
              oCapEn <= 1'b1;
            end
          end
          CAPTURE: begin
            if (fe) oCapEn <= 1'b0;
            if (fs) oCapEn <= 1'b1;
            if (iStop) state <= STOPPING;
          end
          STOPPING: begin
            if (!oCapEn || fe) begin
              state  <= IDLE;
              oCapEn <= 1'b0;
            end
          end
          default: begin
            state  <= IDLE;
            oCapEn <= 1'b0;
          end
        endcase

        if (complete_c) begin
          if (!iRdBusy) begin
            oRdBank   <= oWrBank;
            oWrBank   <= ~oWrBank;
            oRdValid  <= 1'b1;
            oSwap     <= 1'b1;
            oFrameCnt <= oFrameCnt + CNT_W'(1);
          end else begin
            oDrop <= 1'b1;
          end
        end
      end
    end
  end

`ifdef CAMERA_SCHED_STATS_EN
  logic [CNT_W-1:0] drop_cnt;

  // Saturating count of frames discarded because the reader held its bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt <= '0;
    end else if (complete_c && iRdBusy && (drop_cnt != {CNT_W{1'b1}})) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  assign oDropCnt = drop_cnt;
`else
  assign oDropCnt = '0;
`endif

endmodule

// File: tb/tb_camera_frame_scheduler.sv
// Self-checking bench for camera_frame_scheduler: directed scenarios plus
// randomized frames, checked against a frame-level reference model.
module tb_camera_frame_scheduler;

  localparam int unsigned SKIP = 2;
  localparam int unsigned CW   = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cfg_done = 1'b0;
  logic          vsync = 1'b1;
  logic          rd_busy = 1'b0;
  logic          cap_en;
  logic          wr_bank;
  logic          rd_bank;
  logic          rd_valid;
  logic          swap;
  logic          drop;
  logic [CW-1:0] frame_cnt;
  logic [CW-1:0] drop_cnt;

  always #5 clk = ~clk;

  camera_frame_scheduler #(.SKIP_FRAMES(SKIP), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .iStart   (start),
    .iStop    (stop),
    .iCfgDone (cfg_done),
    .iVsync   (vsync),
    .iRdBusy  (rd_busy),
    .oCapEn   (cap_en),
    .oWrBank  (wr_bank),
    .oRdBank  (rd_bank),
    .oRdValid (rd_valid),
    .oSwap    (swap),
    .oDrop    (drop),
    .oFrameCnt(frame_cnt),
    .oDropCnt (drop_cnt)
  );

  int n_vec = 0;
  int n_err = 0;
  int swap_seen = 0;
  int drop_seen = 0;

  // Reference model state: frame-level view of the scheduler
  bit m_run = 1'b0;
  int m_skip = 0;
  bit m_wr = 1'b0;
  bit m_rd = 1'b1;
  bit m_valid = 1'b0;
  int m_fcnt = 0;
  int m_dcnt = 0;
  int m_swaps = 0;
  int m_drops = 0;

  // Pulse counters, sampled mid-cycle
  always @(negedge clk) begin
    if (swap) swap_seen++;
    if (drop) drop_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int exp_dcnt();
`ifdef CAMERA_SCHED_STATS_EN
    return (m_dcnt > 65535) ? 65535 : m_dcnt;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_skip = 0; m_wr = 1'b0; m_rd = 1'b1;
    m_valid = 1'b0; m_fcnt = 0; m_dcnt = 0;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_capen"}, 32'(cap_en), 32'(0));
    check_eq({tag, "_wr"}, 32'(wr_bank), 32'(0));
    check_eq({tag, "_rd"}, 32'(rd_bank), 32'(1));
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'(0));
    check_eq({tag, "_swap"}, 32'(swap), 32'(0));
    check_eq({tag, "_drop"}, 32'(drop), 32'(0));
    check_eq({tag, "_fcnt"}, 32'(frame_cnt), 32'(0));
    check_eq({tag, "_dcnt"}, 32'(drop_cnt), 32'(0));
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_fcnt"}, 32'(frame_cnt), 32'(m_fcnt % 65536));
    check_eq({tag, "_dcnt"}, 32'(drop_cnt), 32'(exp_dcnt()));
    check_eq({tag, "_wr"}, 32'(wr_bank), 32'(m_wr));
    check_eq({tag, "_rd"}, 32'(rd_bank), 32'(m_rd));
    check_eq({tag, "_valid"}, 32'(rd_valid), 32'(m_valid));
    check_eq({tag, "_nswap"}, 32'(swap_seen), 32'(m_swaps));
    check_eq({tag, "_ndrop"}, 32'(drop_seen), 32'(m_drops));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    if (!m_run) begin
      m_run = 1'b1;
      m_skip = SKIP;
    end
  endtask

  // One full VSYNC frame: low (active) then high (blanking)
  task automatic run_frame(input bit busy, input bit do_stop, input bit poke_start);
    bit cap;
    int lo;
    int hi;
    lo = $urandom_range(14, 8);
    hi = $urandom_range(12, 7);
    cap = m_run && (m_skip == 0);
    vsync = 1'b0;
    rd_busy = busy;
    tick(3);
    check_eq("fs_latency_capen", 32'(cap_en), 32'(0));
    tick(1);
    check_eq("fs_capen", 32'(cap_en), 32'(cap));
    tick(2);
    if (do_stop) begin
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
    end else begin
      tick(1);
    end
    tick(lo - 7);
    check_eq("mid_capen", 32'(cap_en), 32'(cap));
    vsync = 1'b1;
    tick(3);
    check_eq("fe_latency_capen", 32'(cap_en), 32'(cap));
    check_eq("fe_latency_swap", 32'(swap), 32'(0));
    tick(1);
    check_eq("fe_capen", 32'(cap_en), 32'(0));
    check_eq("fe_swap", 32'(swap), 32'(cap && !busy));
    check_eq("fe_drop", 32'(drop), 32'(cap && busy));
    // Frame-level outcome
    if (cap) begin
      if (busy) begin
        m_drops++; m_dcnt++;
      end else begin
        m_rd = m_wr; m_wr = ~m_wr; m_valid = 1'b1; m_fcnt++; m_swaps++;
      end
    end else if (m_run && !do_stop) begin
      m_skip--;
    end
    if (do_stop) m_run = 1'b0;
    if (poke_start) begin
      pulse_start();
      tick(hi - 8);
    end else begin
      tick(hi - 4);
    end
    check_state("frame");
  endtask

  initial begin
    // Reset values
    tick(3);
    check_reset("reset");
    rst_n = 1'b1;
    cfg_done = 1'b1;
    tick(5);

    // Start and stop together: stop wins, frames are ignored
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    tick(3);
    run_frame(1'b0, 1'b0, 1'b0);

    // Two skipped frames, then two delivered frames
    pulse_start();
    for (int i = 0; i < 4; i++) run_frame(1'b0, 1'b0, 1'b0);
    check_eq("t1_fcnt", 32'(frame_cnt), 32'(2));
    check_eq("t1_wr", 32'(wr_bank), 32'(0));
    check_eq("t1_rd", 32'(rd_bank), 32'(1));
    check_eq("t1_valid", 32'(rd_valid), 32'(1));

    // Reader busy at FE: drop, banks hold
    run_frame(1'b1, 1'b0, 1'b0);
    check_eq("busy_fcnt", 32'(frame_cnt), 32'(2));
    check_eq("busy_rd", 32'(rd_bank), 32'(1));
`ifdef CAMERA_SCHED_STATS_EN
    check_eq("busy_dcnt", 32'(drop_cnt), 32'(1));
`else
    check_eq("busy_dcnt", 32'(drop_cnt), 32'(0));
`endif

    // Randomized frames with busy, stop and stray start requests
    for (int i = 0; i < 24; i++) begin
      bit b;
      bit s;
      bit p;
      b = ($urandom_range(2, 0) == 0);
      s = ($urandom_range(7, 0) == 0);
      p = ($urandom_range(3, 0) == 0) || !m_run || s;
      run_frame(b, s, p);
    end

    // Reach capture, then stop mid-frame: one final swap, later frames ignored
    for (int i = 0; i < 4 && !(m_run && m_skip == 0); i++)
      run_frame(1'b0, 1'b0, !m_run);
    run_frame(1'b0, 1'b1, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);

    // Start mid-frame: the partial frame's FE consumes one skip
    vsync = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(6);
    check_eq("midstart_capen", 32'(cap_en), 32'(0));
    vsync = 1'b1;
    tick(8);
    check_eq("midstart_capen_fe", 32'(cap_en), 32'(0));
    m_run = 1'b1;
    m_skip = SKIP - 1;
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0);

    // Config drop mid-capture aborts; re-assert restarts the skip sequence
    vsync = 1'b0;
    tick(6);
    check_eq("abort_pre_capen", 32'(cap_en), 32'(1));
    cfg_done = 1'b0;
    tick(1);
    check_eq("abort_capen", 32'(cap_en), 32'(0));
    tick(3);
    vsync = 1'b1;
    tick(8);
    check_state("abort");
    cfg_done = 1'b1;
    tick(3);
    m_skip = SKIP;
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-capture
    vsync = 1'b0;
    tick(6);
    check_eq("rst_pre_capen", 32'(cap_en), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("async_rst");
    model_reset();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    vsync = 1'b1;
    tick(8);
    check_state("post_rst");
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0);
    pulse_start();
    for (int i = 0; i < 3; i++) run_frame(1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
